// File: rtl/cpu_bus_xfer.sv
`default_nettype none
// ============================================================================
// Module  : cpu_bus_xfer
// Purpose : Multi-byte transfer sequencer between the CPU request port and the
//           byte-serial memory bus. Moves 1..MAX_BYTES bytes as handshaked
//           beats, ascending or descending, little-endian, with optional sign
//           extension on reads and a per-beat wait timeout.
// Revision: 1.0 - initial release
// ============================================================================
module cpu_bus_xfer #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BYTES = 4,
  parameter int TIMEOUT   = 255,
  parameter int NB_W      = $clog2(MAX_BYTES + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_req,
  input  logic                   i_we,
  input  logic                   i_desc,
  input  logic                   i_sext,
  input  logic [ADDR_W-1:0]      i_addr,
  input  logic [NB_W-1:0]        i_nbytes,
  input  logic [8*MAX_BYTES-1:0] i_wdata,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  output logic [8*MAX_BYTES-1:0] o_rdata,
  output logic                   o_bus_clk,
  output logic                   o_bus_we,
  output logic [ADDR_W-1:0]      o_bus_addr,
  output logic [DATA_W-1:0]      o_bus_data,
  input  logic [DATA_W-1:0]      i_bus_data,
  input  logic                   i_bus_data_ready
);

  localparam int              BW     = 8 * MAX_BYTES;
  localparam int              TC_W   = $clog2(TIMEOUT + 1);
  localparam logic [NB_W-1:0] MAX_NB = NB_W'(MAX_BYTES);
  localparam logic [NB_W-1:0] ONE_NB = NB_W'(1);
  localparam logic [TC_W-1:0] TC_MAX = TC_W'(TIMEOUT);
  localparam logic [TC_W-1:0] TC_ONE = TC_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_RELEASE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            state;
  logic              we_q;
  logic              desc_q;
  logic              sext_q;
  logic [ADDR_W-1:0] addr_q;
  logic [NB_W-1:0]   nb_q;
  logic [NB_W-1:0]   k;
  logic [BW-1:0]     wdata_q;
  logic [BW-1:0]     rbuf;
  logic [TC_W-1:0]   tcnt;

  logic [NB_W-1:0]   k_nxt;
  logic [NB_W-1:0]   cur_pos;
  logic [ADDR_W-1:0] nxt_addr;
  logic [7:0]        nxt_byte;
  logic [NB_W-1:0]   req_nb;
  logic [7:0]        first_byte;

  // Only the low byte of the bus data pins carries data.
  generate
    if (DATA_W > 8) begin : g_unused_data
      logic unused_bus_hi;
      assign unused_bus_hi = ^i_bus_data[DATA_W-1:8];
    end
  endgenerate

  // Address of beat idx, wrapping modulo 2^ADDR_W in either direction.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                  input logic desc,
                                                  input logic [NB_W-1:0] idx);
    return desc ? (base - ADDR_W'(idx)) : (base + ADDR_W'(idx));
  endfunction

  // Little-endian byte slot touched by beat idx; descending walks high byte first.
  function automatic logic [NB_W-1:0] byte_pos(input logic desc,
                                               input logic [NB_W-1:0] n,
                                               input logic [NB_W-1:0] idx);
    return desc ? (n - idx - ONE_NB) : idx;
  endfunction

  // Byte select that stays in range when a look-ahead slot is past the end.
  function automatic logic [7:0] sel_byte(input logic [BW-1:0] d,
                                          input logic [NB_W-1:0] pos);
    if (pos < MAX_NB) return d[8*pos +: 8];
    else              return 8'h00;
  endfunction

  // Fill bytes at or above n with zero or the sign bit of byte n-1.
  function automatic logic [BW-1:0] fill_upper(input logic [BW-1:0] d,
                                               input logic [NB_W-1:0] n,
                                               input logic sx);
    logic [BW-1:0] r;
    logic          s;
    int            nn;
    nn = int'(n);
    r  = d;
    s  = sx & d[8*nn-1];
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i >= nn) r[8*i +: 8] = {8{s}};
    end
    return r;
  endfunction

  // Beat look-ahead: next index, its address/byte, and the clamped request size.
  always_comb begin
    k_nxt      = k + ONE_NB;
    cur_pos    = byte_pos(desc_q, nb_q, k);
    nxt_addr   = beat_addr(addr_q, desc_q, k_nxt);
    nxt_byte   = we_q ? sel_byte(wdata_q, byte_pos(desc_q, nb_q, k_nxt)) : 8'h00;
    req_nb     = (i_nbytes > MAX_NB) ? MAX_NB : i_nbytes;
    first_byte = i_we ? sel_byte(i_wdata, i_desc ? (req_nb - ONE_NB) : {NB_W{1'b0}})
                      : 8'h00;
  end

  // Transfer sequencer with registered bus and status outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      we_q       <= 1'b0;
      desc_q     <= 1'b0;
      sext_q     <= 1'b0;
      addr_q     <= '0;
      nb_q       <= '0;
      k          <= '0;
      wdata_q    <= '0;
      rbuf       <= '0;
      tcnt       <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_rdata    <= '0;
      o_bus_clk  <= 1'b0;
      o_bus_we   <= 1'b0;
      o_bus_addr <= '0;
      o_bus_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_req) begin
            we_q    <= i_we;
            desc_q  <= i_desc;
            sext_q  <= i_sext;
            addr_q  <= i_addr;
            nb_q    <= req_nb;
            wdata_q <= i_wdata;
            k       <= '0;
            tcnt    <= '0;
            rbuf    <= '0;
            o_busy  <= 1'b1;
            if (req_nb == '0) begin
              // Empty request: no bus traffic, DONE emits the pulse itself.
              state <= S_DONE;
            end else begin
              state      <= S_ASSERT;
              o_bus_clk  <= 1'b1;
              o_bus_we   <= i_we;
              o_bus_addr <= i_addr;
              o_bus_data <= DATA_W'(first_byte);
            end
          end
        end

        S_ASSERT: begin
          if (i_bus_data_ready) begin
            if (!we_q) rbuf[8*cur_pos +: 8] <= i_bus_data[7:0];
            o_bus_clk <= 1'b0;
            tcnt      <= '0;
            state     <= S_RELEASE;
          end else if (tcnt == TC_MAX) begin
            o_bus_clk <= 1'b0;
            o_done    <= 1'b1;
            o_err     <= 1'b1;
            tcnt      <= '0;
            state     <= S_DONE;
          end else begin
            tcnt <= tcnt + TC_ONE;
          end
        end

        S_RELEASE: begin
          if (!i_bus_data_ready) begin
            tcnt <= '0;
            if (k_nxt < nb_q) begin
              k          <= k_nxt;
              state      <= S_ASSERT;
              o_bus_clk  <= 1'b1;
              o_bus_addr <= nxt_addr;
              o_bus_data <= DATA_W'(nxt_byte);
            end else begin
              o_done <= 1'b1;
              state  <= S_DONE;
              if (!we_q) o_rdata <= fill_upper(rbuf, nb_q, sext_q);
            end
          end else if (tcnt == TC_MAX) begin
            o_done <= 1'b1;
            o_err  <= 1'b1;
            tcnt   <= '0;
            state  <= S_DONE;
          end else begin
            tcnt <= tcnt + TC_ONE;
          end
        end

        S_DONE: begin
          if (o_done) begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            o_busy <= 1'b0;
            state  <= S_IDLE;
          end else begin
            o_done <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_xfer.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_bus_xfer
// Purpose : Self-checking bench for cpu_bus_xfer with a configurable
//           wait-state responder, beat/completion scoreboard and a vector table.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cpu_bus_xfer;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we, desc, sext;
  logic [31:0] addr;
  logic [2:0]  nbytes;
  logic [31:0] wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        bus_clk, bus_we;
  logic [31:0] bus_addr, bus_data_o, bus_data_i;
  logic        bus_ready;

  cpu_bus_xfer #(.ADDR_W(32), .DATA_W(32), .MAX_BYTES(4), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_desc(desc),
    .i_sext(sext), .i_addr(addr), .i_nbytes(nbytes), .i_wdata(wdata),
    .o_busy(busy), .o_done(done), .o_err(err), .o_rdata(rdata),
    .o_bus_clk(bus_clk), .o_bus_we(bus_we), .o_bus_addr(bus_addr),
    .o_bus_data(bus_data_o), .i_bus_data(bus_data_i),
    .i_bus_data_ready(bus_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder memory contents.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 8'h11;
      32'h0000_1001: return 8'h22;
      32'h0000_1002: return 8'h33;
      32'h0000_1003: return 8'h44;
      32'h0000_2000: return 8'h80;
      32'h0000_2001: return 8'h9A;
      32'hFFFF_FFFF: return 8'h5A;
      32'h0000_0000: return 8'hA5;
      default:       return a[7:0] ^ 8'h3C;
    endcase
  endfunction

  always_comb bus_data_i = {24'h0, mem_byte(bus_addr)};

  // Responder: ready follows bus_clk after wait_cyc cycles (0 = same cycle).
  int   wait_cyc = 0;
  bit   dead = 1'b0;
  logic ready_q = 1'b0;
  int   wcnt = 0;
  always @(posedge clk) begin
    if (bus_clk != ready_q) begin
      if (wcnt >= wait_cyc - 1) begin
        ready_q <= bus_clk;
        wcnt    <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end
  assign bus_ready = dead ? 1'b0 : ((wait_cyc == 0) ? bus_clk : ready_q);

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [7:0]  data;
  } beat_t;

  typedef struct {
    int          start;
    int          cycles;
    logic        err;
    logic [31:0] rdata;
  } done_t;

  typedef struct {
    logic        we, desc, sext;
    logic [31:0] addr;
    logic [2:0]  nb;
    logic [31:0] wdata;
    int          wt;
    bit          dead;
    logic [31:0] exp_rdata;
    int          exp_cyc;
    logic        exp_err;
  } vec_t;

  beat_t beat_q[$];
  done_t done_q[$];
  int    n_chk = 0;
  int    n_err = 0;
  logic  prev_bclk = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every new bus strobe against the next expected beat.
  task automatic sample_beats();
    beat_t b;
    if (bus_clk && !prev_bclk) begin
      if (beat_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_strobe: addr %0h with no beat pending", bus_addr);
      end else begin
        b = beat_q.pop_front();
        chk("beat_addr", 64'(bus_addr), 64'(b.addr));
        chk("beat_we", 64'(bus_we), 64'(b.we));
        if (b.we) chk("beat_data", 64'(bus_data_o), {56'h0, b.data});
      end
    end
    prev_bclk = bus_clk;
  endtask

  task automatic check_done();
    done_t d;
    if (done_q.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL done_unexpected: o_done with empty scoreboard");
    end else begin
      d = done_q.pop_front();
      chk("done_cycle", 64'(cyc - d.start), 64'(d.cycles));
      chk("done_err", 64'(err), 64'(d.err));
      chk("done_rdata", 64'(rdata), 64'(d.rdata));
      chk("done_busclk", 64'(bus_clk), 64'd0);
      chk("done_busy", 64'(busy), 64'd1);
      chk("beats_left", 64'(beat_q.size()), 64'd0);
    end
  endtask

  // Drive one request at the current negedge; returns one cycle after o_done.
  task automatic run(input vec_t v);
    int    n, nbeats, pos;
    bit    seen;
    beat_t b;
    wait_cyc = v.wt;
    dead     = v.dead;
    we = v.we; desc = v.desc; sext = v.sext;
    addr = v.addr; nbytes = v.nb; wdata = v.wdata;
    req = 1'b1;
    n = (int'(v.nb) > 4) ? 4 : int'(v.nb);
    nbeats = (v.dead && n > 0) ? 1 : n;
    for (int k = 0; k < nbeats; k++) begin
      pos    = v.desc ? (n - 1 - k) : k;
      b.addr = v.desc ? (v.addr - 32'(k)) : (v.addr + 32'(k));
      b.we   = v.we;
      b.data = v.wdata[8*pos +: 8];
      beat_q.push_back(b);
    end
    done_q.push_back('{cyc, v.exp_cyc, v.exp_err, v.exp_rdata});
    @(negedge clk);
    req = 1'b0;
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_strobe", 64'(bus_clk), 64'(n > 0));
    seen = 1'b0;
    for (int g = 0; g < 200 && !seen; g++) begin
      sample_beats();
      if (done) begin
        seen = 1'b1;
        check_done();
      end else begin
        @(negedge clk);
      end
    end
    if (!seen) begin
      n_chk++;
      n_err++;
      $display("FAIL done_timeout: no o_done within 200 cycles");
      done_q.delete();
    end
    beat_q.delete();
    @(negedge clk);
    sample_beats();
    chk("done_pulse_end", 64'({done, busy}), 64'd0);
  endtask

  function automatic vec_t mk(input logic w, input logic d, input logic s,
                              input logic [31:0] a, input logic [2:0] nb,
                              input logic [31:0] wd, input int wt, input bit dd,
                              input logic [31:0] er, input int ec, input logic ee);
    vec_t v;
    v.we = w; v.desc = d; v.sext = s; v.addr = a; v.nb = nb; v.wdata = wd;
    v.wt = wt; v.dead = dd; v.exp_rdata = er; v.exp_cyc = ec; v.exp_err = ee;
    return v;
  endfunction

  vec_t vecs[13];
  vec_t zr;
  bit   hit;

  initial begin
    //               we    desc  sext  addr          nb    wdata         wt dead exp_rdata     cyc err
    vecs[0]  = mk(1'b0, 1'b0, 1'b0, 32'h0000_1000, 3'd4, 32'h0,        0, 0, 32'h4433_2211, 9,  1'b0);
    vecs[1]  = mk(1'b1, 1'b1, 1'b0, 32'h0000_01FF, 3'd2, 32'h0000_BEEF, 0, 0, 32'h4433_2211, 5,  1'b0);
    vecs[2]  = mk(1'b0, 1'b0, 1'b1, 32'h0000_2000, 3'd1, 32'h0,        0, 0, 32'hFFFF_FF80, 3,  1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 32'h0000_2000, 3'd1, 32'h0,        0, 0, 32'h0000_0080, 3,  1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 3'd2, 32'h0,        3, 0, 32'h0000_A55A, 17, 1'b0);
    vecs[5]  = mk(1'b0, 1'b1, 1'b1, 32'h0000_1003, 3'd3, 32'h0,        0, 0, 32'h0044_3322, 7,  1'b0);
    vecs[6]  = mk(1'b1, 1'b0, 1'b0, 32'h0000_3000, 3'd4, 32'hCAFE_F00D, 1, 0, 32'h0044_3322, 17, 1'b0);
    vecs[7]  = mk(1'b0, 1'b0, 1'b0, 32'h0000_1000, 3'd7, 32'h0,        0, 0, 32'h4433_2211, 9,  1'b0);
    vecs[8]  = mk(1'b0, 1'b0, 1'b1, 32'h0000_2000, 3'd2, 32'h0,        0, 0, 32'hFFFF_9A80, 5,  1'b0);
    vecs[9]  = mk(1'b1, 1'b0, 1'b0, 32'h0000_4000, 3'd0, 32'h1234_5678, 0, 0, 32'hFFFF_9A80, 2,  1'b0);
    vecs[10] = mk(1'b0, 1'b0, 1'b0, 32'h0000_1000, 3'd4, 32'h0,        0, 1, 32'hFFFF_9A80, 10, 1'b1);
    vecs[11] = mk(1'b0, 1'b0, 1'b0, 32'h0000_2001, 3'd1, 32'h0,        0, 0, 32'h0000_009A, 3,  1'b0);
    vecs[12] = mk(1'b0, 1'b1, 1'b1, 32'h0000_0000, 3'd2, 32'h0,        2, 0, 32'hFFFF_A55A, 13, 1'b0);
    zr       = mk(1'b0, 1'b0, 1'b0, 32'h0000_5000, 3'd0, 32'h0,        0, 0, 32'h0,         2,  1'b0);

    rst_n = 1'b0; req = 1'b0; we = 1'b0; desc = 1'b0; sext = 1'b0;
    addr = '0; nbytes = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 64'({busy, done, err, bus_clk, bus_we}), 64'd0);
    chk("reset_addr", 64'(bus_addr), 64'd0);
    chk("reset_data", 64'(bus_data_o), 64'd0);
    chk("reset_rdata", 64'(rdata), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors, issued back-to-back.
    for (int i = 0; i < 13; i++) run(vecs[i]);

    // Reset while a beat strobe is high.
    wait_cyc = 3; dead = 1'b0;
    we = 1'b0; desc = 1'b0; sext = 1'b0; addr = 32'h0000_1000; nbytes = 3'd4;
    beat_q.push_back('{32'h0000_1000, 1'b0, 8'h00});
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    hit = 1'b0;
    for (int g = 0; g < 20 && !hit; g++) begin
      sample_beats();
      if (bus_clk) hit = 1'b1;
      else @(negedge clk);
    end
    if (!hit) begin
      n_chk++;
      n_err++;
      $display("FAIL midbeat_strobe: bus strobe never rose");
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ctrl", 64'({busy, done, err, bus_clk, bus_we}), 64'd0);
    chk("midrst_addr", 64'(bus_addr), 64'd0);
    chk("midrst_data", 64'(bus_data_o), 64'd0);
    chk("midrst_rdata", 64'(rdata), 64'd0);
    @(negedge clk);
    chk("midrst_nodone", 64'(done), 64'd0);
    rst_n = 1'b1;
    beat_q.delete();
    prev_bclk = bus_clk;
    @(negedge clk);
    chk("postrst_nodone", 64'({done, busy}), 64'd0);

    // Empty read after reset: pulse at cycle 2, no strobe.
    run(zr);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
